xif_mac_coproc: RTL and testbench

//  CV-X-IF coprocessor on the core's eXtension interface (compressed/issue/commit/result).

---
 rtl/xif_mac_coproc.sv | 241 ++++++++++++++++++++++++
 tb/tb_xif_mac_coproc.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xif_mac_coproc.sv
// CV-X-IF coprocessor: custom-0 MAC/RDH/CLR on a private 64-bit accumulator.
// Ports: compressed (never accepts), issue (decode/accept), commit (kill/commit
// by id), result (rd writeback). One instruction in flight, 32-cycle shift-add.
module xif_mac_coproc #(
    parameter int unsigned X_NUM_RS    = 2,
    parameter int unsigned X_ID_WIDTH  = 4,
    parameter int unsigned X_RFR_WIDTH = 32,
    parameter logic [6:0]  OPCODE      = 7'h0B
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            compressed_valid_i,
    output logic                            compressed_ready_o,
    output logic [31:0]                     compressed_resp_instr_o,
    output logic                            compressed_resp_accept_o,
    input  logic                            issue_valid_i,
    output logic                            issue_ready_o,
    input  logic [31:0]                     issue_req_instr_i,
    input  logic [X_ID_WIDTH-1:0]           issue_req_id_i,
    input  logic [X_NUM_RS*X_RFR_WIDTH-1:0] issue_req_rs_i,
    input  logic [X_NUM_RS-1:0]             issue_req_rs_valid_i,
    output logic                            issue_resp_accept_o,
    output logic                            issue_resp_writeback_o,
    output logic                            issue_resp_dualwrite_o,
    output logic [2:0]                      issue_resp_dualread_o,
    output logic                            issue_resp_loadstore_o,
    output logic                            issue_resp_ecswrite_o,
    output logic                            issue_resp_exc_o,
    input  logic                            commit_valid_i,
    input  logic [X_ID_WIDTH-1:0]           commit_id_i,
    input  logic                            commit_kill_i,
    output logic                            result_valid_o,
    input  logic                            result_ready_i,
    output logic [X_ID_WIDTH-1:0]           result_id_o,
    output logic [31:0]                     result_data_o,
    output logic [4:0]                      result_rd_o,
    output logic                            result_we_o,
    output logic [5:0]                      result_ecsdata_o,
    output logic [2:0]                      result_ecswe_o,
    output logic                            result_exc_o,
    output logic [5:0]                      result_exccode_o,
    output logic                            result_err_o,
    output logic                            result_dbg_o
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        WAIT_COMMIT,
        RESULT
    } state_e;

    localparam logic [1:0] OP_MAC = 2'd0;
    localparam logic [1:0] OP_RDH = 2'd1;

    state_e                  state_q, state_d;
    logic [63:0]             acc_q, acc_d;
    logic [63:0]             prod_q, prod_d;
    logic [X_ID_WIDTH-1:0]   id_q, id_d;
    logic [4:0]              rd_q, rd_d;
    logic [1:0]              op_q, op_d;
    logic [31:0]             rs1_q, rs1_d;
    logic [31:0]             rs2_q, rs2_d;
    logic [5:0]              cnt_q, cnt_d;
    logic                    committed_q, committed_d;
    logic [31:0]             data_q, data_d;

    logic [2:0]              funct3;
    logic                    is_ours;
    logic                    is_mac;
    logic                    rs_ok;
    logic                    idle;
    logic                    hs;
    logic                    acc_hs;
    logic [X_ID_WIDTH-1:0]   cmt_id;
    logic                    cmt_hit;
    logic                    cmt_ok;
    logic                    cmt_kill;
    logic [63:0]             addend;
    logic [63:0]             prod_step;
    logic [63:0]             prod_fin;
    logic                    finish;
    logic                    unused_sig;

    assign unused_sig = ^{compressed_valid_i, issue_req_instr_i[24:15]};

    assign funct3  = issue_req_instr_i[14:12];
    assign is_ours = (issue_req_instr_i[6:0] == OPCODE)
                  && (issue_req_instr_i[31:25] == 7'd0)
                  && (funct3 inside {3'b000, 3'b001, 3'b010});
    assign is_mac  = is_ours && (funct3 == 3'b000);
    assign rs_ok   = (issue_req_rs_valid_i[1:0] == 2'b11);
    assign idle    = (state_q == IDLE);

    // A MAC offer holds off the handshake until both operands are valid.
    assign issue_ready_o = idle && !(issue_valid_i && is_mac && !rs_ok);
    assign hs            = issue_valid_i && issue_ready_o;
    assign acc_hs        = hs && is_ours;

    // In the handshake cycle the commit matches against the offered id.
    assign cmt_id   = idle ? issue_req_id_i : id_q;
    assign cmt_hit  = commit_valid_i && (commit_id_i == cmt_id)
                   && (acc_hs || state_q == BUSY || state_q == WAIT_COMMIT);
    assign cmt_ok   = cmt_hit && !commit_kill_i;
    assign cmt_kill = cmt_hit && commit_kill_i;

    assign addend    = rs2_q[cnt_q[4:0]] ? ({32'd0, rs1_q} << cnt_q[4:0])
                                         : 64'd0;
    assign prod_step = prod_q + addend;
    assign prod_fin  = (state_q == BUSY) ? prod_step : prod_q;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        prod_d      = prod_q;
        id_d        = id_q;
        rd_d        = rd_q;
        op_d        = op_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        cnt_d       = cnt_q;
        committed_d = committed_q;
        data_d      = data_q;
        finish      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (acc_hs) begin
                    id_d        = issue_req_id_i;
                    rd_d        = issue_req_instr_i[11:7];
                    op_d        = funct3[1:0];
                    rs1_d       = issue_req_rs_i[31:0];
                    rs2_d       = issue_req_rs_i[63:32];
                    cnt_d       = 6'd0;
                    prod_d      = 64'd0;
                    committed_d = cmt_ok;
                    if (!cmt_kill) begin
                        state_d = is_mac ? BUSY : WAIT_COMMIT;
                    end
                end
            end
            BUSY: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + 6'd1;
                if (cmt_ok) begin
                    committed_d = 1'b1;
                end
                if (cmt_kill) begin
                    state_d = IDLE;
                end else if (cnt_q == 6'd31) begin
                    if (committed_q || cmt_ok) begin
                        finish = 1'b1;
                    end else begin
                        state_d = WAIT_COMMIT;
                    end
                end
            end
            WAIT_COMMIT: begin
                if (cmt_kill) begin
                    state_d = IDLE;
                end else if (committed_q || cmt_ok) begin
                    finish = 1'b1;
                end
            end
            RESULT: begin
                if (result_ready_i) begin
                    state_d     = IDLE;
                    committed_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // The accumulator only changes on the edge that enters RESULT.
        if (finish) begin
            state_d = RESULT;
            if (op_q == OP_MAC) begin
                acc_d  = acc_q + prod_fin;
                data_d = acc_d[31:0];
            end else if (op_q == OP_RDH) begin
                data_d = acc_q[63:32];
            end else begin
                acc_d  = 64'd0;
                data_d = 32'd0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            acc_q       <= 64'd0;
            prod_q      <= 64'd0;
            id_q        <= '0;
            rd_q        <= 5'd0;
            op_q        <= 2'd0;
            rs1_q       <= 32'd0;
            rs2_q       <= 32'd0;
            cnt_q       <= 6'd0;
            committed_q <= 1'b0;
            data_q      <= 32'd0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            prod_q      <= prod_d;
            id_q        <= id_d;
            rd_q        <= rd_d;
            op_q        <= op_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            cnt_q       <= cnt_d;
            committed_q <= committed_d;
            data_q      <= data_d;
        end
    end

    assign compressed_ready_o       = 1'b1;
    assign compressed_resp_instr_o  = 32'd0;
    assign compressed_resp_accept_o = 1'b0;

    assign issue_resp_accept_o    = acc_hs;
    assign issue_resp_writeback_o = acc_hs;
    assign issue_resp_dualwrite_o = 1'b0;
    assign issue_resp_dualread_o  = 3'd0;
    assign issue_resp_loadstore_o = 1'b0;
    assign issue_resp_ecswrite_o  = 1'b0;
    assign issue_resp_exc_o       = 1'b0;

    assign result_valid_o   = (state_q == RESULT);
    assign result_we_o      = (state_q == RESULT);
    assign result_id_o      = id_q;
    assign result_rd_o      = rd_q;
    assign result_data_o    = data_q;
    assign result_ecsdata_o = 6'd0;
    assign result_ecswe_o   = 3'd0;
    assign result_exc_o     = 1'b0;
    assign result_exccode_o = 6'd0;
    assign result_err_o     = 1'b0;
    assign result_dbg_o     = 1'b0;

endmodule

// File: tb/tb_xif_mac_coproc.sv
// Directed bench for xif_mac_coproc: issue/commit/result sequences with a
// scoreboard of expected writebacks and a bench-side accumulator model.
module tb_xif_mac_coproc;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        compressed_valid_i = 1'b0;
    logic        compressed_ready_o;
    logic [31:0] compressed_resp_instr_o;
    logic        compressed_resp_accept_o;
    logic        issue_valid_i = 1'b0;
    logic        issue_ready_o;
    logic [31:0] issue_req_instr_i = 32'd0;
    logic [3:0]  issue_req_id_i = 4'd0;
    logic [63:0] issue_req_rs_i = 64'd0;
    logic [1:0]  issue_req_rs_valid_i = 2'b00;
    logic        issue_resp_accept_o;
    logic        issue_resp_writeback_o;
    logic        issue_resp_dualwrite_o;
    logic [2:0]  issue_resp_dualread_o;
    logic        issue_resp_loadstore_o;
    logic        issue_resp_ecswrite_o;
    logic        issue_resp_exc_o;
    logic        commit_valid_i = 1'b0;
    logic [3:0]  commit_id_i = 4'd0;
    logic        commit_kill_i = 1'b0;
    logic        result_valid_o;
    logic        result_ready_i = 1'b0;
    logic [3:0]  result_id_o;
    logic [31:0] result_data_o;
    logic [4:0]  result_rd_o;
    logic        result_we_o;
    logic [5:0]  result_ecsdata_o;
    logic [2:0]  result_ecswe_o;
    logic        result_exc_o;
    logic [5:0]  result_exccode_o;
    logic        result_err_o;
    logic        result_dbg_o;

    xif_mac_coproc dut (
        .clk_i                    (clk),
        .rst_ni                   (rst_ni),
        .compressed_valid_i       (compressed_valid_i),
        .compressed_ready_o       (compressed_ready_o),
        .compressed_resp_instr_o  (compressed_resp_instr_o),
        .compressed_resp_accept_o (compressed_resp_accept_o),
        .issue_valid_i            (issue_valid_i),
        .issue_ready_o            (issue_ready_o),
        .issue_req_instr_i        (issue_req_instr_i),
        .issue_req_id_i           (issue_req_id_i),
        .issue_req_rs_i           (issue_req_rs_i),
        .issue_req_rs_valid_i     (issue_req_rs_valid_i),
        .issue_resp_accept_o      (issue_resp_accept_o),
        .issue_resp_writeback_o   (issue_resp_writeback_o),
        .issue_resp_dualwrite_o   (issue_resp_dualwrite_o),
        .issue_resp_dualread_o    (issue_resp_dualread_o),
        .issue_resp_loadstore_o   (issue_resp_loadstore_o),
        .issue_resp_ecswrite_o    (issue_resp_ecswrite_o),
        .issue_resp_exc_o         (issue_resp_exc_o),
        .commit_valid_i           (commit_valid_i),
        .commit_id_i              (commit_id_i),
        .commit_kill_i            (commit_kill_i),
        .result_valid_o           (result_valid_o),
        .result_ready_i           (result_ready_i),
        .result_id_o              (result_id_o),
        .result_data_o            (result_data_o),
        .result_rd_o              (result_rd_o),
        .result_we_o              (result_we_o),
        .result_ecsdata_o         (result_ecsdata_o),
        .result_ecswe_o           (result_ecswe_o),
        .result_exc_o             (result_exc_o),
        .result_exccode_o         (result_exccode_o),
        .result_err_o             (result_err_o),
        .result_dbg_o             (result_dbg_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] acc_m = 64'd0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [2:0] f3,
                                       input logic [4:0] rd);
        return {7'd0, 5'd2, 5'd1, f3, rd, 7'h0B};
    endfunction

    // Offer one instruction that must be accepted; optionally commit it
    // in the handshake cycle. Returns in cycle 1 relative to the handshake.
    task automatic issue(input string tag, input logic [2:0] f3,
                         input logic [4:0] rd, input logic [3:0] id,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit cmt);
        issue_valid_i        = 1'b1;
        issue_req_instr_i    = mk(f3, rd);
        issue_req_id_i       = id;
        issue_req_rs_i       = {b, a};
        issue_req_rs_valid_i = 2'b11;
        commit_valid_i       = cmt;
        commit_id_i          = id;
        commit_kill_i        = 1'b0;
        #1;
        chk({tag, "_rdy"}, 64'(issue_ready_o), 64'd1);
        chk({tag, "_acc"}, 64'({issue_resp_accept_o,
                                issue_resp_writeback_o}), 64'd3);
        step();
        issue_valid_i  = 1'b0;
        commit_valid_i = 1'b0;
    endtask

    function automatic void push_exp(input logic [2:0] f3,
                                     input logic [4:0] rd,
                                     input logic [3:0] id,
                                     input logic [31:0] a,
                                     input logic [31:0] b);
        exp_t e;
        e.id = id;
        e.rd = rd;
        if (f3 == 3'b000) begin
            acc_m  = acc_m + 64'(a) * 64'(b);
            e.data = acc_m[31:0];
        end else if (f3 == 3'b001) begin
            e.data = acc_m[63:32];
        end else begin
            acc_m  = 64'd0;
            e.data = 32'd0;
        end
        sb.push_back(e);
    endfunction

    // Wait (bounded) for result_valid_o, check latency and fields against
    // the scoreboard head, then complete the handshake.
    task automatic take(input string tag, input int start, input int exp_cyc);
        int   cyc;
        exp_t e;
        cyc = start;
        while (!result_valid_o && cyc < 200) begin
            step();
            cyc++;
        end
        chk({tag, "_lat"}, 64'(cyc), 64'(exp_cyc));
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_data"}, 64'(result_data_o), 64'(e.data));
            chk({tag, "_rd"}, 64'(result_rd_o), 64'(e.rd));
            chk({tag, "_id"}, 64'(result_id_o), 64'(e.id));
            chk({tag, "_we"}, 64'(result_we_o), 64'd1);
        end
        result_ready_i = 1'b1;
        step();
        result_ready_i = 1'b0;
        chk({tag, "_idle_v"}, 64'(result_valid_o), 64'd0);
        chk({tag, "_idle_r"}, 64'(issue_ready_o), 64'd1);
    endtask

    initial begin
        #2;
        chk("rst_valid", 64'(result_valid_o), 64'd0);
        chk("rst_cready", 64'(compressed_ready_o), 64'd1);
        chk("rst_ready", 64'(issue_ready_o), 64'd1);
        chk("rst_accept", 64'(issue_resp_accept_o), 64'd0);
        step();
        rst_ni = 1'b1;
        step();

        // 1: 3*5 into an empty accumulator
        push_exp(3'b000, 5'd10, 4'd2, 32'd3, 32'd5);
        issue("t1", 3'b000, 5'd10, 4'd2, 32'd3, 32'd5, 1'b1);
        take("t1", 1, 33);

        // 2: full-width product wraps into the high word
        push_exp(3'b000, 5'd11, 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue("t2m", 3'b000, 5'd11, 4'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
        take("t2m", 1, 33);
        push_exp(3'b001, 5'd12, 4'd4, 32'd0, 32'd0);
        issue("t2h", 3'b001, 5'd12, 4'd4, 32'd0, 32'd0, 1'b1);
        take("t2h", 1, 2);

        // 3: kill in cycle 10 drops the MAC
        issue("t3", 3'b000, 5'd13, 4'd5, 32'd7, 32'd9, 1'b0);
        repeat (9) step();
        commit_valid_i = 1'b1;
        commit_id_i    = 4'd5;
        commit_kill_i  = 1'b1;
        step();
        commit_valid_i = 1'b0;
        commit_kill_i  = 1'b0;
        chk("t3_ready", 64'(issue_ready_o), 64'd1);
        chk("t3_valid", 64'(result_valid_o), 64'd0);
        repeat (3) step();
        chk("t3_valid2", 64'(result_valid_o), 64'd0);
        push_exp(3'b001, 5'd14, 4'd6, 32'd0, 32'd0);
        issue("t3h", 3'b001, 5'd14, 4'd6, 32'd0, 32'd0, 1'b1);
        take("t3h", 1, 2);

        // 4: foreign and compressed instructions, MAC without operands
        issue_valid_i        = 1'b1;
        issue_req_instr_i    = 32'h00000013;
        issue_req_rs_valid_i = 2'b11;
        compressed_valid_i   = 1'b1;
        #1;
        chk("t4_rdy", 64'(issue_ready_o), 64'd1);
        chk("t4_acc", 64'(issue_resp_accept_o), 64'd0);
        chk("t4_cacc", 64'(compressed_resp_accept_o), 64'd0);
        step();
        compressed_valid_i = 1'b0;
        chk("t4_idle", 64'(issue_ready_o), 64'd1);
        issue_req_instr_i    = mk(3'b000, 5'd1);
        issue_req_rs_valid_i = 2'b01;
        #1;
        chk("t4_rsw_rdy", 64'(issue_ready_o), 64'd0);
        chk("t4_rsw_acc", 64'(issue_resp_accept_o), 64'd0);
        issue_req_instr_i = mk(3'b011, 5'd1);
        #1;
        chk("t4_f3_acc", 64'(issue_resp_accept_o), 64'd0);
        issue_valid_i = 1'b0;
        step();

        // 5: late commit, stray commit ignored, result back-pressure
        push_exp(3'b000, 5'd3, 4'd9, 32'h12345678, 32'h10);
        issue("t5", 3'b000, 5'd3, 4'd9, 32'h12345678, 32'h10, 1'b0);
        for (int c = 1; c < 40; c++) begin
            if (c == 20) begin
                commit_valid_i = 1'b1;
                commit_id_i    = 4'd4;
            end
            if (c == 36) begin
                chk("t5_wait", 64'(result_valid_o), 64'd0);
            end
            step();
            commit_valid_i = 1'b0;
        end
        commit_valid_i = 1'b1;
        commit_id_i    = 4'd9;
        step();
        commit_valid_i = 1'b0;
        chk("t5_v41", 64'(result_valid_o), 64'd1);
        for (int k = 0; k < 5; k++) begin
            chk("t5_hold_d", 64'(result_data_o), 64'h23456790);
            chk("t5_hold_id", 64'(result_id_o), 64'd9);
            step();
        end
        take("t5", 41, 41);

        // 6: async reset in BUSY drops the op and clears the accumulator
        issue("t6", 3'b000, 5'd5, 4'd7, 32'd3, 32'd5, 1'b1);
        repeat (5) step();
        #2;
        rst_ni = 1'b0;
        acc_m  = 64'd0;
        #1;
        chk("t6_valid", 64'(result_valid_o), 64'd0);
        chk("t6_ready", 64'(issue_ready_o), 64'd1);
        step();
        rst_ni = 1'b1;
        step();
        push_exp(3'b001, 5'd6, 4'd8, 32'd0, 32'd0);
        issue("t6h", 3'b001, 5'd6, 4'd8, 32'd0, 32'd0, 1'b1);
        take("t6h", 1, 2);
        push_exp(3'b000, 5'd7, 4'd1, 32'd6, 32'd7);
        issue("t6m", 3'b000, 5'd7, 4'd1, 32'd6, 32'd7, 1'b1);
        take("t6m", 1, 33);
        push_exp(3'b010, 5'd8, 4'd2, 32'd0, 32'd0);
        issue("t6c", 3'b010, 5'd8, 4'd2, 32'd0, 32'd0, 1'b1);
        take("t6c", 1, 2);
        push_exp(3'b000, 5'd9, 4'd3, 32'd1, 32'd1);
        issue("t6z", 3'b000, 5'd9, 4'd3, 32'd1, 32'd1, 1'b1);
        take("t6z", 1, 33);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
